// File: rtl/nn_mem_pkg.sv
// Shared constants, address-vector types and requester state encoding for the
// NN memory arbiter and its requester clients.
package nn_mem_pkg;

  localparam int unsigned LANES   = 8;
  localparam int unsigned CADDR_W = 17;
  localparam int unsigned MADDR_W = 16;
  localparam int unsigned CNT_W   = 8;

  typedef logic [LANES-1:0][CADDR_W-1:0] caddr_vec_t;
  typedef logic [LANES-1:0][MADDR_W-1:0] maddr_vec_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } req_state_e;

endpackage

// File: rtl/nn_lane_addr_gen.sv
// Expands a base pointer into a burst of consecutive lane addresses,
// wrapping modulo 2^W.
module nn_lane_addr_gen #(
  parameter int unsigned W     = nn_mem_pkg::CADDR_W,
  parameter int unsigned LANES = nn_mem_pkg::LANES
) (
  input  logic [W-1:0]            base_i,
  output logic [LANES-1:0][W-1:0] lanes_o
);

  always_comb begin
    lanes_o = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lanes_o[i] = base_i + W'(i);
    end
  end

endmodule

// File: rtl/nn_mem_requester.sv
// Arbiter client: on start, requests the memory ports and walks a sequence of
// LANES-wide address bursts, stalling whenever grant is withdrawn.
module nn_mem_requester #(
  parameter int unsigned LANES   = nn_mem_pkg::LANES,
  parameter int unsigned CADDR_W = nn_mem_pkg::CADDR_W,
  parameter int unsigned MADDR_W = nn_mem_pkg::MADDR_W,
  parameter int unsigned CNT_W   = nn_mem_pkg::CNT_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [CADDR_W-1:0]            cfg_base,
  input  logic [MADDR_W-1:0]            mem_base,
  input  logic [CNT_W-1:0]              num_bursts,
  output logic                          request,
  input  logic                          grant,
  output logic [LANES-1:0][CADDR_W-1:0] Caddress,
  output logic [LANES-1:0][MADDR_W-1:0] Maddress,
  output logic                          addr_valid,
  output logic                          busy,
  output logic                          done
);

  import nn_mem_pkg::req_state_e;
  import nn_mem_pkg::IDLE;
  import nn_mem_pkg::ACTIVE;
  import nn_mem_pkg::DONE;

  req_state_e         state_q, state_d;
  logic [CADDR_W-1:0] cfg_ptr_q, cfg_ptr_d;
  logic [MADDR_W-1:0] mem_ptr_q, mem_ptr_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic               request_q, request_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cfg_ptr_q   <= '0;
      mem_ptr_q   <= '0;
      remaining_q <= '0;
      request_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_ptr_q   <= cfg_ptr_d;
      mem_ptr_q   <= mem_ptr_d;
      remaining_q <= remaining_d;
      request_q   <= request_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next state; request/busy/done are registered decodes of the next state.
  always_comb begin
    state_d     = state_q;
    cfg_ptr_d   = cfg_ptr_q;
    mem_ptr_d   = mem_ptr_q;
    remaining_d = remaining_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          cfg_ptr_d   = cfg_base;
          mem_ptr_d   = mem_base;
          remaining_d = num_bursts;
          state_d     = (num_bursts != '0) ? ACTIVE : DONE;
        end
      end
      ACTIVE: begin
        if (grant) begin
          cfg_ptr_d   = cfg_ptr_q + CADDR_W'(LANES);
          mem_ptr_d   = mem_ptr_q + MADDR_W'(LANES);
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    request_d = (state_d == ACTIVE);
    busy_d    = (state_d == ACTIVE);
    done_d    = (state_d == DONE);
  end

  nn_lane_addr_gen #(.W(CADDR_W), .LANES(LANES)) u_cfg_lanes (
    .base_i  (cfg_ptr_q),
    .lanes_o (Caddress)
  );

  nn_lane_addr_gen #(.W(MADDR_W), .LANES(LANES)) u_mem_lanes (
    .base_i  (mem_ptr_q),
    .lanes_o (Maddress)
  );

  assign addr_valid = request_q && grant;
  assign request    = request_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_nn_mem_requester.sv
// Scoreboard bench for nn_mem_requester: stimulus pushes expected bursts and
// done cycles, a negedge monitor pops and compares whenever the DUT presents them.
module tb_nn_mem_requester;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic [16:0]          cfg_base;
  logic [15:0]          mem_base;
  logic [7:0]           num_bursts;
  logic                 request;
  logic                 grant;
  logic [7:0][16:0]     Caddress;
  logic [7:0][15:0]     Maddress;
  logic                 addr_valid;
  logic                 busy;
  logic                 done;

  typedef struct packed {
    logic [16:0] c;
    logic [15:0] m;
  } exp_t;

  exp_t bq[$];
  int   dq[$];
  int   cyc;
  int   n_cmp;
  int   n_err;

  exp_t        mon_e;
  int          mon_bad;
  int          mon_d;
  logic [16:0] mon_ec;
  logic [15:0] mon_em;

  nn_mem_requester dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cfg_base   (cfg_base),
    .mem_base   (mem_base),
    .num_bursts (num_bursts),
    .request    (request),
    .grant      (grant),
    .Caddress   (Caddress),
    .Maddress   (Maddress),
    .addr_valid (addr_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_burst(input logic [16:0] c, input logic [15:0] m);
    bq.push_back('{c: c, m: m});
  endtask

  // Called at #1 after a posedge; extra < 0 means no done pulse is expected.
  task automatic start_cmd(input logic [16:0] cb, input logic [15:0] mb,
                           input logic [7:0] n, input int extra);
    cfg_base   = cb;
    mem_base   = mb;
    num_bursts = n;
    start      = 1'b1;
    if (extra >= 0) dq.push_back(cyc + int'(n) + 1 + extra);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while ((bq.size() != 0 || dq.size() != 0) && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    check(name, 32'(t < 100), 32'd1);
  endtask

  // Monitor: every presented burst and done pulse must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (addr_valid) begin
        n_cmp++;
        if (bq.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_burst: got C0=0x%0h expected no burst (cycle %0d)", Caddress[0], cyc);
        end else begin
          mon_e   = bq.pop_front();
          mon_bad = -1;
          for (int i = 0; i < 8; i++) begin
            mon_ec = mon_e.c + 17'(i);
            mon_em = mon_e.m + 16'(i);
            if ((Caddress[i] !== mon_ec || Maddress[i] !== mon_em) && mon_bad < 0) mon_bad = i;
          end
          if (mon_bad >= 0) begin
            n_err++;
            $display("FAIL burst_lane%0d: got C=0x%0h M=0x%0h expected base C=0x%0h M=0x%0h (cycle %0d)",
                     mon_bad, Caddress[mon_bad], Maddress[mon_bad], mon_e.c, mon_e.m, cyc);
          end
        end
      end
      if (done) begin
        if (dq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: got done=1 expected 0 (cycle %0d)", cyc);
        end else begin
          mon_d = dq.pop_front();
          check("done_cycle", 32'(cyc), 32'(mon_d));
        end
      end
    end
  end

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    grant      = 1'b0;
    cfg_base   = '0;
    mem_base   = '0;
    num_bursts = '0;

    // Reset state
    #3;
    check("rst_request", 32'(request), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_caddr3", 32'(Caddress[3]), 32'h3);
    check("rst_maddr7", 32'(Maddress[7]), 32'h7);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Grant without start is ignored
    grant = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_addr_valid", 32'(addr_valid), 32'd0);
      check("idle_request", 32'(request), 32'd0);
    end
    @(posedge clk);
    #1;

    // Basic three-burst run
    push_burst(17'h00100, 16'h0200);
    push_burst(17'h00108, 16'h0208);
    push_burst(17'h00110, 16'h0210);
    start_cmd(17'h00100, 16'h0200, 8'd3, 0);
    check("run_busy", 32'(busy), 32'd1);
    check("run_caddr0", 32'(Caddress[0]), 32'h100);
    check("run_maddr7", 32'(Maddress[7]), 32'h207);
    wait_idle("basic_complete");

    // Preemption: grant withdrawn for two cycles after the second burst
    push_burst(17'h00400, 16'h0800);
    push_burst(17'h00408, 16'h0808);
    push_burst(17'h00410, 16'h0810);
    push_burst(17'h00418, 16'h0818);
    start_cmd(17'h00400, 16'h0800, 8'd4, 2);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    grant = 1'b0;
    #1;
    check("stall1_request", 32'(request), 32'd1);
    check("stall1_caddr0", 32'(Caddress[0]), 32'h410);
    check("stall1_valid", 32'(addr_valid), 32'd0);
    @(posedge clk);
    #1;
    check("stall2_request", 32'(request), 32'd1);
    check("stall2_maddr0", 32'(Maddress[0]), 32'h810);
    @(posedge clk);
    #1;
    grant = 1'b1;
    wait_idle("stall_complete");

    // Zero-length command
    start_cmd(17'h01234, 16'h0567, 8'd0, 0);
    check("zero_request0", 32'(request), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("zero_request", 32'(request), 32'd0);
    end
    @(posedge clk);
    #1;
    wait_idle("zero_complete");

    // Address wrap across the top of both spaces
    push_burst(17'h1FFFC, 16'hFFFC);
    push_burst(17'h00004, 16'h0004);
    start_cmd(17'h1FFFC, 16'hFFFC, 8'd2, 0);
    check("wrap_caddr4", 32'(Caddress[4]), 32'h0);
    check("wrap_maddr3", 32'(Maddress[3]), 32'hFFFF);
    wait_idle("wrap_complete");

    // Start pulsed mid-run is ignored
    push_burst(17'h02000, 16'h3000);
    push_burst(17'h02008, 16'h3008);
    push_burst(17'h02010, 16'h3010);
    push_burst(17'h02018, 16'h3018);
    start_cmd(17'h02000, 16'h3000, 8'd4, 0);
    @(posedge clk);
    #1;
    cfg_base   = 17'h07000;
    mem_base   = 16'h7000;
    num_bursts = 8'd9;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle("midstart_complete");
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset mid-run abandons the sequence
    push_burst(17'h00300, 16'h0400);
    push_burst(17'h00308, 16'h0408);
    start_cmd(17'h00300, 16'h0400, 8'd5, -1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_request", 32'(request), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_valid", 32'(addr_valid), 32'd0);
    check("arst_caddr3", 32'(Caddress[3]), 32'h3);
    repeat (2) begin
      @(negedge clk);
      check("arst_done", 32'(done), 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("arst_bursts_seen", 32'(bq.size()), 32'd0);
    @(posedge clk);
    #1;
    push_burst(17'h00040, 16'h0080);
    start_cmd(17'h00040, 16'h0080, 8'd1, 0);
    wait_idle("post_reset_complete");

    repeat (5) @(posedge clk);
    #1;
    check("final_burst_queue", 32'(bq.size()), 32'd0);
    check("final_done_queue", 32'(dq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
